pipe_adder_nbit: RTL and testbench
==================================

# pipe_adder_nbit

Parametrised, pipelined N-bit adder/subtractor. It is the sequential successor to the team's 1-bit half adder: operand width is generic, the carry chain is split into CHUNK-bit slices with one register stage per slice, and a subtract mode with signed-overflow detection is added. A valid/ready handshake with full-pipeline stall lets it sit between streaming datapath blocks running at full clock rate.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK, and 1 ≤ STAGES ≤ 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present on a, b, cin, sub.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1.
- out_valid  output  1  result present on sum, cout, ovf.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; in subtract mode this is 1 when no borrow occurs (a ≥ b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- stall = out_valid & ~out_ready. in_ready = ~stall. The check is combinational, with no path from in_valid.
- When stall=1, every pipeline register holds, including valid bits, partial sums, carries and delayed operand slices. Outputs stay stable.
- When stall=0, each stage advances one position. A bubble (in_valid=0) propagates as valid=0.
- Stage k (0..STAGES−1) adds slice k of a and b' (b'=~b when sub=1, else b), plus the carry registered by stage k−1. For stage 0 that carry is cin when sub=0 and 1 when sub=1.
- Slices above k travel delayed, unmodified, alongside the operation. Sum slices below k travel already computed. The sub flag travels with its operation.
- The final stage registers sum, cout and ovf. The ovf input is the carry into bit WIDTH−1, taken from the MSB slice's internal carry.
- Operations never reorder, drop or duplicate.
- Reset (rst=1 at a clock edge) overrides stall and data: all valid bits clear to 0, and sum, cout, ovf and all internal registers clear to 0.
- Operations in flight at reset are discarded and never emerge. in_valid is ignored during the reset cycle.

## Timing
- Latency is STAGES cycles. An operation accepted at edge t is presented with out_valid=1 after edge t+STAGES−1, assuming no stalls. Each stall cycle adds one cycle.
- With CHUNK=WIDTH, STAGES=1: the result is registered one edge after acceptance.
- Throughput is one operation per cycle while out_ready=1.
- After rst deasserts: out_valid=0 and in_ready=1 in the first cycle. Output values after reset: out_valid=0, sum=0, cout=0, ovf=0.
- When the pipeline is full and out_ready drops, in_ready drops in the same cycle. When out_ready rises, in_ready rises in the same cycle, so an input and an output may transfer together.
- When out_valid=0, sum, cout and ovf are don't-care to the consumer. The block nevertheless holds the last computed value, or 0 after reset.
- Critical path is one CHUNK-bit ripple plus carry mux.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, STAGES=4.
- Reset: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0, and no output appears afterwards.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0, sub=0 → 4 cycles later sum=16'h0000, cout=1, ovf=0. Also a=16'h7FFF, b=0, cin=1 → sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1 → sum=16'hFFFE, cout=0, ovf=0. a=16'h8000, b=16'h0001, sub=1 → sum=16'h7FFF, cout=1, ovf=1.
- Streaming: 64 back-to-back random operations with mixed sub and cin, out_ready=1 → one result per cycle, in order, matching a reference model, with first result at latency 4.
- Stall: fill the pipeline, drop out_ready for 3 cycles, then raise it → in_ready=0 and outputs stable during the stall, with no loss or duplication. Repeat with random out_ready at 50% duty against a scoreboard.
- Mid-flight reset: accept 3 operations, assert rst for 1 cycle → out_valid=0 the next cycle and none of the 3 results ever appear. An operation accepted after reset emerges 4 cycles later with the correct value.

Source files
------------

// File: rtl/pipe_adder_nbit.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per register stage,
// valid/ready handshake with whole-pipeline stall, signed-overflow flag on the result.
module pipe_adder_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic             ovf_q;

    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             sub_d [STAGES];
    logic             ovf_d;

    logic             stall;
    logic [CHUNK:0]   t;

    // One slice of the carry chain; b is inverted here so delayed slices stay raw.
    function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             inv,
                                                 input logic             ci);
        logic [CHUNK-1:0] yy;
        yy = inv ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {{CHUNK{1'b0}}, ci};
    endfunction

    assign stall     = vld_q[LAST] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    always_comb begin
        t        = add_slice(a[CHUNK-1:0], b[CHUNK-1:0], sub, sub | cin);
        vld_d[0] = in_valid;
        a_d[0]   = a;
        b_d[0]   = b;
        sub_d[0] = sub;
        s_d[0]   = '0;
        s_d[0][CHUNK-1:0] = t[CHUNK-1:0];
        c_d[0]   = t[CHUNK];
        for (int k = 1; k < STAGES; k++) begin
            t        = add_slice(a_q[k-1][k*CHUNK +: CHUNK], b_q[k-1][k*CHUNK +: CHUNK],
                                 sub_q[k-1], c_q[k-1]);
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sub_d[k] = sub_q[k-1];
            s_d[k]   = s_q[k-1];
            s_d[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
            c_d[k]   = t[CHUNK];
        end
        // a ^ b' ^ sum at the MSB recovers the carry into bit WIDTH-1.
        ovf_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ sub_d[LAST]
              ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            // Data only loads behind a valid op so bubbles keep the last result visible.
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    s_q[k]   <= s_d[k];
                    c_q[k]   <= c_d[k];
                    sub_q[k] <= sub_d[k];
                end
            end
            if (vld_d[LAST]) ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// Randomised bench for pipe_adder_nbit (16-bit, 4-bit chunks) against a queue-based
// arithmetic model that tracks each operation's remaining cycles to the output.
module tb_pipe_adder_nbit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    always #5 clk = ~clk;

    pipe_adder_nbit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          rem;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] f;
        exp_t        e;
        yy    = sb ? ~y : y;
        f     = {1'b0, x} + {1'b0, yy} + {16'd0, (sb ? 1'b1 : ci)};
        e.s   = f[15:0];
        e.c   = f[16];
        e.o   = (x[15] == yy[15]) && (f[15] != x[15]);
        e.rem = 3;
        return e;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs and advance the model.
    task automatic cyc(input logic r, input logic iv, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic sb, input logic ordy);
        logic exp_ov;
        logic exp_stall;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; in_valid = iv; a = x; b = y; cin = ci; sub = sb; out_ready = ordy;
        @(negedge clk);
        exp_ov = (q.size() > 0) && (q[0].rem == 0);
        check1("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check1("sum", 32'(sum), 32'(q[0].s));
            check1("cout", 32'(cout), 32'(q[0].c));
            check1("ovf", 32'(ovf), 32'(q[0].o));
        end
        exp_stall = exp_ov && !ordy;
        check1("in_ready", 32'(in_ready), 32'(!exp_stall));
        if (r) begin
            q.delete();
        end else if (!exp_stall) begin
            if (exp_ov) e = q.pop_front();
            foreach (q[i]) q[i].rem = q[i].rem - 1;
            if (iv) q.push_back(model(x, y, ci, sb));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rnd_op(input logic ordy);
        cyc(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    initial begin
        exp_t e;

        // Pin the model to hand-computed results.
        e = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check1("model_ripple", {e.s, 14'd0, e.c, e.o}, {16'h0000, 14'd0, 1'b1, 1'b0});
        e = model(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        check1("model_cin_ovf", {e.s, 14'd0, e.c, e.o}, {16'h8000, 14'd0, 1'b0, 1'b1});
        e = model(16'h0005, 16'h0007, 1'b0, 1'b1);
        check1("model_sub_neg", {e.s, 14'd0, e.c, e.o}, {16'hFFFE, 14'd0, 1'b0, 1'b0});
        e = model(16'h8000, 16'h0001, 1'b1, 1'b1);
        check1("model_sub_ovf", {e.s, 14'd0, e.c, e.o}, {16'h7FFF, 14'd0, 1'b1, 1'b1});

        // Reset held two cycles with in_valid high.
        cyc(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        idle(1);
        check1("rst_sum", 32'(sum), 32'h0);
        check1("rst_cout", 32'(cout), 32'h0);
        check1("rst_ovf", 32'(ovf), 32'h0);
        idle(5);

        // Directed carry-ripple and subtract cases, back to back.
        cyc(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
        idle(6);

        // Streaming at full rate.
        for (int i = 0; i < 64; i++) rnd_op(1'b1);
        idle(6);

        // Fill, stall three cycles, release.
        for (int i = 0; i < 4; i++) rnd_op(1'b1);
        for (int i = 0; i < 3; i++) rnd_op(1'b0);
        for (int i = 0; i < 4; i++) rnd_op(1'b1);
        idle(6);

        // Random backpressure and bubbles.
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(8);

        // Mid-flight reset discards in-flight work.
        for (int i = 0; i < 3; i++) rnd_op(1'b1);
        cyc(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1);
        idle(1);
        cyc(1'b0, 1'b1, 16'h1234, 16'h0FF0, 1'b1, 1'b1, 1'b1);
        idle(6);

        check1("drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
